// File: rtl/libv_deque_arb.sv
// Round-robin command arbiter for a single libv_deque: issues at most one
// push/pop per cycle, tracks occupancy and routes pop data back to the winner.

package libv_deque_pkg;
    typedef enum logic [1:0] {
        PushFront = 2'd0,
        PopFront  = 2'd1,
        PushBack  = 2'd2,
        PopBack   = 2'd3
    } cmd_t;
endpackage

module libv_deque_arb #(
    parameter int W = 32,
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [R-1:0]                      req_vld,
    input  libv_deque_pkg::cmd_t [R-1:0]      req_op,
    input  logic [R-1:0][W-1:0]               req_data,
    output logic [R-1:0]                      req_rdy,
    output logic [R-1:0]                      rsp_vld,
    output logic [W-1:0]                      rsp_data,
    output logic                              cmd_vld,
    output libv_deque_pkg::cmd_t              cmd_op,
    output logic [W-1:0]                      cmd_push_data,
    input  logic [W-1:0]                      cmd_pop_data,
    output logic [$clog2(N+1)-1:0]            count_r,
    output logic                              empty_r,
    output logic                              full_r
);
    import libv_deque_pkg::*;

    localparam int RW = $clog2(R);
    localparam int CW = $clog2(N+1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [RW-1:0] rr_reg;
    logic [RW-1:0] rr_next;
    logic [R-1:0]  rsp_vld_reg;
    logic [W-1:0]  rsp_data_reg;

    logic [R-1:0]  is_pop;
    logic [R-1:0]  eligible;
    logic [R-1:0]  grant;
    logic [RW-1:0] winner;
    logic          found;
    logic          pop_issued;
    logic          push_issued;

    assign empty_r = (count_reg == '0);
    assign full_r  = (count_reg == CW'(N));

    // A request is eligible only if the deque can accept it this cycle;
    // ineligible requests simply wait, they are never dropped.
    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_elig
            assign is_pop[gi]   = (req_op[gi] == PopFront) || (req_op[gi] == PopBack);
            assign eligible[gi] = req_vld[gi] && !rst && (is_pop[gi] ? !empty_r : !full_r);
        end
    endgenerate

    // Rotating search starting at rr_reg; first eligible requester wins.
    always_comb begin
        logic [RW:0] idx_ext;
        grant   = '0;
        winner  = '0;
        found   = 1'b0;
        idx_ext = '0;
        for (int off = 0; off < R; off++) begin
            idx_ext = {1'b0, rr_reg} + (RW+1)'(off);
            if (idx_ext >= (RW+1)'(R)) begin
                idx_ext = idx_ext - (RW+1)'(R);
            end
            if (!found && eligible[idx_ext[RW-1:0]]) begin
                found                     = 1'b1;
                winner                    = idx_ext[RW-1:0];
                grant[idx_ext[RW-1:0]]    = 1'b1;
            end
        end
    end

    assign req_rdy       = grant;
    assign cmd_vld       = found;
    assign cmd_op        = found ? req_op[winner] : PushFront;
    assign cmd_push_data = found ? req_data[winner] : '0;
    assign pop_issued    = found && is_pop[winner];
    assign push_issued   = found && !is_pop[winner];

    always_comb begin
        count_next = count_reg;
        rr_next    = rr_reg;
        if (push_issued) begin
            count_next = count_reg + CW'(1);
        end else if (pop_issued) begin
            count_next = count_reg - CW'(1);
        end
        if (found) begin
            rr_next = (winner == RW'(R-1)) ? '0 : winner + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            rr_reg       <= '0;
            rsp_vld_reg  <= '0;
            rsp_data_reg <= '0;
        end else begin
            count_reg   <= count_next;
            rr_reg      <= rr_next;
            rsp_vld_reg <= pop_issued ? grant : '0;
            // Pop data is only meaningful for the cycle's pop; otherwise hold.
            if (pop_issued) begin
                rsp_data_reg <= cmd_pop_data;
            end
        end
    end

    assign count_r  = count_reg;
    assign rsp_vld  = rsp_vld_reg;
    assign rsp_data = rsp_data_reg;

endmodule

// File: tb/tb_libv_deque_arb.sv
// Table-driven bench for libv_deque_arb with a small behavioural deque
// supplying combinational pop data.

module tb_libv_deque_arb;
    import libv_deque_pkg::*;

    localparam int W = 32;
    localparam int N = 8;
    localparam int R = 4;

    logic                  clk;
    logic                  rst;
    logic [R-1:0]          req_vld;
    cmd_t [R-1:0]          req_op;
    logic [R-1:0][W-1:0]   req_data;
    logic [R-1:0]          req_rdy;
    logic [R-1:0]          rsp_vld;
    logic [W-1:0]          rsp_data;
    logic                  cmd_vld;
    cmd_t                  cmd_op;
    logic [W-1:0]          cmd_push_data;
    logic [W-1:0]          cmd_pop_data;
    logic [3:0]            count_r;
    logic                  empty_r;
    logic                  full_r;

    int total = 0;
    int bad   = 0;

    libv_deque_arb #(.W(W), .N(N), .R(R)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_op(req_op), .req_data(req_data), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data),
        .cmd_vld(cmd_vld), .cmd_op(cmd_op), .cmd_push_data(cmd_push_data),
        .cmd_pop_data(cmd_pop_data),
        .count_r(count_r), .empty_r(empty_r), .full_r(full_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural deque: circular buffer, front at head.
    logic [W-1:0] mem [N];
    logic [2:0]   head;
    logic [3:0]   tcnt;
    logic [2:0]   back_idx;
    assign back_idx     = head + tcnt[2:0] - 3'd1;
    assign cmd_pop_data = (cmd_op == PopFront) ? mem[head] : mem[back_idx];

    always @(posedge clk) begin
        if (rst) begin
            head <= 3'd0;
            tcnt <= 4'd0;
        end else if (cmd_vld) begin
            case (cmd_op)
                PushFront: begin
                    mem[head - 3'd1] <= cmd_push_data;
                    head <= head - 3'd1;
                    tcnt <= tcnt + 4'd1;
                end
                PushBack: begin
                    mem[head + tcnt[2:0]] <= cmd_push_data;
                    tcnt <= tcnt + 4'd1;
                end
                PopFront: begin
                    head <= head + 3'd1;
                    tcnt <= tcnt - 4'd1;
                end
                default: tcnt <= tcnt - 4'd1;
            endcase
        end
    end

    typedef struct packed {
        logic         rst;
        logic [3:0]   vld;
        logic [7:0]   op;
        logic [127:0] data;
        logic [3:0]   exp_rdy;
        logic [3:0]   exp_cnt;
        logic [3:0]   exp_rsp;
        logic [31:0]  exp_rdata;
    } vec_t;

    vec_t vecs [39];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [7:0] o,
                                input logic [127:0] d, input logic [3:0] rdy,
                                input logic [3:0] cnt, input logic [3:0] rsp,
                                input logic [31:0] rd);
        vec_t x;
        x.rst = r; x.vld = v; x.op = o; x.data = d;
        x.exp_rdy = rdy; x.exp_cnt = cnt; x.exp_rsp = rsp; x.exp_rdata = rd;
        return x;
    endfunction

    task automatic chk(input string nm, input int vi, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, vi, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [7:0] o,
                         input logic [127:0] d);
        rst     = r;
        req_vld = v;
        for (int i = 0; i < R; i++) begin
            req_op[i]   = cmd_t'(o[2*i +: 2]);
            req_data[i] = d[32*i +: 32];
        end
    endtask

    initial begin
        int n;
        int win;
        logic [7:0] wop;
        logic [127:0] wd;
        n = 0;
        vecs[n++] = mk(1, 4'hF, 8'h00, {32'h103, 32'h102, 32'h101, 32'h100}, 4'h0, 0, 4'h0, 0);
        vecs[n++] = mk(1, 4'hF, 8'h00, {32'h103, 32'h102, 32'h101, 32'h100}, 4'h0, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'hF, 8'h00, {32'h103, 32'h102, 32'h101, 32'h100}, 4'h1, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h01, 128'h0, 4'h1, 1, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h00, 128'hA, 4'h1, 0, 4'h1, 32'h100);
        vecs[n++] = mk(0, 4'h1, 8'h00, 128'hB, 4'h1, 1, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h01, 128'h0, 4'h1, 2, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h01, 128'h0, 4'h1, 1, 4'h1, 32'hB);
        vecs[n++] = mk(0, 4'h1, 8'h00, 128'h11, 4'h1, 0, 4'h1, 32'hA);
        vecs[n++] = mk(0, 4'h1, 8'h02, 128'h22, 4'h1, 1, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h03, 128'h0, 4'h1, 2, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h01, 128'h0, 4'h1, 1, 4'h1, 32'h22);
        vecs[n++] = mk(0, 4'h0, 8'h00, 128'h0, 4'h0, 0, 4'h1, 32'h11);
        for (int k = 0; k < 5; k++)
            vecs[n++] = mk(0, 4'h8, 8'h40, 128'h0, 4'h0, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'h9, 8'h40, 128'h33, 4'h1, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'h8, 8'h40, 128'h0, 4'h8, 1, 4'h0, 0);
        vecs[n++] = mk(0, 4'h0, 8'h00, 128'h0, 4'h0, 0, 4'h8, 32'h33);
        for (int k = 0; k < 8; k++)
            vecs[n++] = mk(0, 4'hF, 8'h00, {32'h43, 32'h42, 32'h41, 32'h40},
                           4'(1 << (k % 4)), 4'(k), 4'h0, 0);
        vecs[n++] = mk(0, 4'hF, 8'h00, {32'h43, 32'h42, 32'h41, 32'h40}, 4'h0, 8, 4'h0, 0);
        vecs[n++] = mk(0, 4'h6, 8'h30, {32'h0, 32'h0, 32'h55, 32'h0}, 4'h4, 8, 4'h0, 0);
        vecs[n++] = mk(0, 4'h2, 8'h00, {32'h0, 32'h0, 32'h55, 32'h0}, 4'h2, 7, 4'h4, 32'h40);
        vecs[n++] = mk(0, 4'h0, 8'h00, 128'h0, 4'h0, 8, 4'h0, 0);
        vecs[n++] = mk(1, 4'hF, 8'h00, 128'h0, 4'h0, 8, 4'h0, 0);
        vecs[n++] = mk(0, 4'h0, 8'h00, 128'h0, 4'h0, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'h1, 8'h00, 128'h77, 4'h1, 0, 4'h0, 0);
        vecs[n++] = mk(0, 4'h2, 8'h04, 128'h0, 4'h2, 1, 4'h0, 0);
        vecs[n++] = mk(0, 4'h4, 8'h10, 128'h0, 4'h0, 0, 4'h2, 32'h77);
        vecs[n++] = mk(0, 4'h4, 8'h10, 128'h0, 4'h0, 0, 4'h0, 0);

        drive(1, 4'h0, 8'h00, 128'h0);
        @(posedge clk); #1;

        for (int i = 0; i < n; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].op, vecs[i].data);
            #2;
            $display("vec %0d rst=%b vld=%b rdy=%b cmd_vld=%b cnt=%0d rsp=%b rsp_data=%h",
                     i, rst, req_vld, req_rdy, cmd_vld, count_r, rsp_vld, rsp_data);
            chk("req_rdy", i, 32'(req_rdy), 32'(vecs[i].exp_rdy));
            chk("cmd_vld", i, 32'(cmd_vld), 32'(vecs[i].exp_rdy != 4'h0));
            win = 0;
            for (int j = 0; j < R; j++) if (vecs[i].exp_rdy[j]) win = j;
            wop = vecs[i].op;
            wd  = vecs[i].data;
            if (vecs[i].exp_rdy != 4'h0) begin
                chk("cmd_op", i, 32'(cmd_op), 32'(wop[2*win +: 2]));
                chk("cmd_push_data", i, cmd_push_data, wd[32*win +: 32]);
            end else begin
                chk("cmd_op_idle", i, 32'(cmd_op), 32'h0);
                chk("cmd_push_data_idle", i, cmd_push_data, 32'h0);
            end
            chk("count_r", i, 32'(count_r), 32'(vecs[i].exp_cnt));
            chk("empty_r", i, 32'(empty_r), 32'(vecs[i].exp_cnt == 4'd0));
            chk("full_r", i, 32'(full_r), 32'(vecs[i].exp_cnt == 4'd8));
            chk("rsp_vld", i, 32'(rsp_vld), 32'(vecs[i].exp_rsp));
            if (vecs[i].exp_rsp != 4'h0) chk("rsp_data", i, rsp_data, vecs[i].exp_rdata);
            if (i < 2) chk("rsp_data_rst", i, rsp_data, 32'h0);
            @(posedge clk); #1;
        end

        // rsp_data holds the last popped word while idle
        drive(0, 4'h0, 8'h00, 128'h0);
        #2;
        $display("seq hold rsp_vld=%b rsp_data=%h", rsp_vld, rsp_data);
        chk("rsp_data_hold", 100, rsp_data, 32'h77);

        // push, then a pop request coincident with reset is discarded
        drive(0, 4'h1, 8'h00, 128'h5);
        #2;
        $display("seq push rdy=%b cnt=%0d", req_rdy, count_r);
        chk("seq_push_rdy", 101, 32'(req_rdy), 32'h1);
        @(posedge clk); #1;
        drive(1, 4'h1, 8'h01, 128'h0);
        #2;
        $display("seq rst_pop rdy=%b cnt=%0d", req_rdy, count_r);
        chk("seq_rst_pop_rdy", 102, 32'(req_rdy), 32'h0);
        chk("seq_rst_pop_cnt", 102, 32'(count_r), 32'h1);
        @(posedge clk); #1;
        drive(0, 4'h0, 8'h00, 128'h0);
        #2;
        $display("seq after_rst rsp=%b cnt=%0d rsp_data=%h", rsp_vld, count_r, rsp_data);
        chk("seq_after_rst_rsp", 103, 32'(rsp_vld), 32'h0);
        chk("seq_after_rst_cnt", 103, 32'(count_r), 32'h0);
        chk("seq_after_rst_data", 103, rsp_data, 32'h0);
        chk("seq_after_rst_empty", 103, 32'(empty_r), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/libv_deque_arb.md
# libv_deque_arb

Multi-requester controller for one `libv_deque` instance. It accepts Push/Pop commands from `R` independent requesters and arbitrates among them round-robin, issuing at most one command per cycle. It also tracks deque occupancy, so a push is never issued when the deque is full and a pop is never issued when it is empty, and it returns pop data to the requester that issued the pop. It sits between client logic and the deque and is the only driver of the deque command port.

## Interface

**Parameters**
- `W`, 32: word width in bits; matches the deque `W`.
- `N`, 8: deque depth in words; matches the deque `N`; power of two, ≥2.
- `R`, 4: number of requesters, ≥2.

**Ports**
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous active-high reset.
- `req_vld`  in  R: request valid, per requester.
- `req_op`  in  R×`libv_deque_pkg::cmd_t`: requested op (PushFront, PopFront, PushBack, PopBack).
- `req_data`  in  R×W: push data.
- `req_rdy`  out  R: grant; one-hot or zero; the request completes in any cycle where `req_vld[i] & req_rdy[i]`.
- `rsp_vld`  out  R: pop response valid, one-hot or zero.
- `rsp_data`  out  W: pop data; valid when `rsp_vld` is nonzero.
- `cmd_vld`  out  1: to deque.
- `cmd_op`  out  `cmd_t`: to deque.
- `cmd_push_data`  out  W: to deque.
- `cmd_pop_data`  in  W: from deque; combinational read for the current op.
- `count_r`  out  $clog2(N+1): current occupancy.
- `empty_r`  out  1: `count_r == 0`.
- `full_r`  out  1: `count_r == N`.

## Operation

**Eligibility**
- Push ops are eligible iff `!full_r`.
- Pop ops are eligible iff `!empty_r`.
- An ineligible request is not dropped. It stays pending with `req_rdy = 0` until it becomes eligible.

**Arbitration**
- Round-robin over eligible, valid requesters.
- The priority pointer `rr_r` starts at 0 on reset.
- After a grant to requester `k`, `rr_r ← (k+1) mod R`. The pointer does not move when nothing is granted.
- Search order is `rr_r, rr_r+1, …` modulo R.

**Issue**
- The grant is combinational, in the same cycle.
- `cmd_vld = |req_rdy`.
- `cmd_op` and `cmd_push_data` are muxed from the winner. `cmd_op` and `cmd_push_data` are don't-care when `cmd_vld = 0`, but must be driven to a known value (zero).
- Requesters must hold `req_op` and `req_data` stable while `req_vld` is high and not granted.

**Occupancy**
- `count_r` increments on an issued push and decrements on an issued pop. Only one op is issued per cycle, so there is no simultaneous increment and decrement.
- The count is never allowed to exceed N or go below 0; eligibility guarantees this.

**Response**
- On an issued pop, `cmd_pop_data` is captured into `rsp_data` and `rsp_vld[k]` is set for the winner.
- Pushes produce no response.
- Responses cannot be backpressured.
- `rsp_data` holds its last value when `rsp_vld = 0`.

**Deque semantics (delegated to the deque)**
- PushFront then PopFront returns the same word; the same holds for PushBack then PopBack.
- Words pushed at one end are popped at that end in LIFO order.

**Reset mid-operation**
- Pending requests are ignored during reset.
- All state clears: `count_r = 0` and `rr_r = 0`.
- The deque pointers are reset by the deque itself on the same `rst`.
- Responses in flight are discarded.

## Timing

**Reset values**
- `req_rdy = 0`, `cmd_vld = 0`, `cmd_op = 0`, `cmd_push_data = 0`.
- `rsp_vld = 0`, `rsp_data = 0`.
- `count_r = 0`, `empty_r = 1`, `full_r = 0`.

**Latency**
- Request to grant: 0 cycles (combinational).
- Grant to `count_r` update: 1 cycle.
- Pop grant to `rsp_vld`: 1 cycle.

**Throughput**
- One command per cycle sustained.
- Back-to-back pops produce back-to-back responses.

**Full/empty boundaries**
- At `count_r == N`, pops remain grantable and pushes stall.
- At 0, pushes remain grantable and pops stall.
- A pop issued at `count_r == 1` makes `empty_r = 1` in the next cycle, so a pop arriving in that next cycle stalls.

**Critical path**
- `req_vld` → arbiter → `cmd_*` → deque address decode → `cmd_pop_data` → `rsp_data` flop.
- No pipelining is permitted; latency is fixed as above.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `req_vld = 1` → `req_rdy = 0`, `rsp_vld = 0`, `count_r = 0`, `empty_r = 1` throughout. First grant after release goes to requester 0.
- **LIFO single requester:** req0 PushFront 0xA, then 0xB; then PopFront twice → `rsp_vld = 4'b0001` with `rsp_data` 0xB then 0xA on consecutive cycles; `count_r` goes 1, 2, 1, 0.
- **Two ends:** PushFront 0x11, PushBack 0x22, PopBack, PopFront → responses 0x22 then 0x11.
- **Full stall (N = 8):** 8 pushes, then req1 push and req2 PopBack both valid → req2 granted, req1 stalls. Next cycle req1 is granted; `count_r` goes 8, 7, 8.
- **Empty stall:** `count_r = 0`, req3 PopFront held for 5 cycles → `req_rdy[3] = 0` and `cmd_vld = 0`. Req0 push is then granted, and req3 is granted on the following cycle.
- **Fairness:** all 4 requesters issue continuous PushFront from empty → grants 0, 1, 2, 3, 0, 1, 2, 3. After the 8th grant, `full_r = 1` and all stall.
